// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the fetch/load-store memory arbiter
package mem_arb_pkg;

    localparam int DEF_XLEN    = 64;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-port signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int XLEN = 64
);

    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [31:0]     if_rdata;
    logic            if_err;

    logic            ls_req;
    logic            ls_we;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_wdata;
    logic [7:0]      ls_wmask;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [XLEN-1:0] ls_rdata;
    logic            ls_err;

    logic            m_req;
    logic            m_we;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic [7:0]      m_wmask;
    logic            m_gnt;
    logic            m_rvalid;
    logic [XLEN-1:0] m_rdata;

    // master: the arbiter itself; slave: requesters plus the memory behind it
    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output m_req, m_we, m_addr, m_wdata, m_wmask,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  m_req, m_we, m_addr, m_wdata, m_wmask,
        output m_gnt, m_rvalid, m_rdata
    );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// rtl/mem_arbiter_arb_rr2.sv - two-way round-robin picker; req[0] = fetch, req[1] = load/store
module arb_rr2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Set when requester 1 won last; reset value gives requester 1 priority first
    logic last_hi;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_hi ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_hi <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            last_hi <= gnt[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter of fetch and load/store onto one memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    mem_arbiter_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    owner_t          owner;
    logic [CW-1:0]   cnt;

    logic            m_req_q;
    logic            m_we_q;
    logic [XLEN-1:0] m_addr_q;
    logic [XLEN-1:0] m_wdata_q;
    logic [7:0]      m_wmask_q;
    logic            if_rvalid_q;
    logic            if_err_q;
    logic [31:0]     if_rdata_q;
    logic            ls_rvalid_q;
    logic            ls_err_q;
    logic [XLEN-1:0] ls_rdata_q;

    logic            arb_en;
    logic [1:0]      gnt;
    logic            misaligned;
    logic            done_ok;
    logic            done_to;
    logic [31:0]     fetch_word;

    // Gated by reset so a held request cannot raise a grant while in reset
    assign arb_en     = (state == ST_IDLE) && !sys_rst;
    assign misaligned = gnt[0] && (bus.if_addr[1:0] != 2'b00);
    assign fetch_word = m_addr_q[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];

    arb_rr2 u_rr (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .req     ({bus.ls_req, bus.if_req} & {2{arb_en}}),
        .advance (arb_en),
        .gnt     (gnt)
    );

    // A real completion beats a timeout landing in the same cycle
    always_comb begin
        done_ok = 1'b0;
        done_to = 1'b0;
        if (state == ST_REQ) begin
            done_ok = bus.m_gnt && bus.m_rvalid;
        end else if (state == ST_WAIT) begin
            done_ok = bus.m_rvalid;
        end
        if ((state == ST_REQ) || (state == ST_WAIT)) begin
            done_to = !done_ok && (cnt == CW'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            owner       <= OWN_IF;
            cnt         <= '0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_wmask_q   <= '0;
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
            case (state)
                ST_IDLE: begin
                    if (gnt[1]) begin
                        owner     <= OWN_LS;
                        m_we_q    <= bus.ls_we;
                        m_addr_q  <= bus.ls_addr;
                        m_wdata_q <= bus.ls_wdata;
                        m_wmask_q <= bus.ls_wmask;
                    end else if (gnt[0]) begin
                        owner     <= OWN_IF;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= bus.if_addr;
                        m_wdata_q <= '0;
                        m_wmask_q <= '0;
                    end
                    if (misaligned) begin
                        state       <= ST_RESP;
                        if_rvalid_q <= 1'b1;
                        if_err_q    <= 1'b1;
                    end else if (gnt != 2'b00) begin
                        state   <= ST_REQ;
                        m_req_q <= 1'b1;
                        cnt     <= '0;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (done_ok || done_to) begin
                        state   <= ST_RESP;
                        m_req_q <= 1'b0;
                        if (owner == OWN_IF) begin
                            if_rvalid_q <= 1'b1;
                            if_err_q    <= done_to;
                            if_rdata_q  <= done_ok ? fetch_word : 32'd0;
                        end else begin
                            ls_rvalid_q <= 1'b1;
                            ls_err_q    <= done_to;
                            ls_rdata_q  <= (done_ok && !m_we_q) ? bus.m_rdata : '0;
                        end
                    end else if ((state == ST_REQ) && bus.m_gnt) begin
                        state   <= ST_WAIT;
                        m_req_q <= 1'b0;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = gnt[0];
    assign bus.ls_gnt    = gnt[1];
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_err    = if_err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_err    = ls_err_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_wmask   = m_wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

    localparam int XLEN = 64;
    localparam int TMO  = 8;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    always #5 sys_clk = ~sys_clk;

    mem_arbiter_if #(.XLEN(XLEN)) bus ();

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    typedef struct {
        logic        is_if;
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] mdata;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge sys_clk);
    endtask

    task automatic chk_all_zero(input string name);
        logic any;
        any = |{bus.if_gnt, bus.if_rvalid, bus.if_err, bus.if_rdata,
                bus.ls_gnt, bus.ls_rvalid, bus.ls_err, bus.ls_rdata,
                bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wmask};
        chk(name, 64'(any), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic mis;
        mis = v.is_if && (v.addr[1:0] != 2'b00);
        next_cycle();
        if (v.is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = v.addr;
        end else begin
            bus.ls_req   = 1'b1;
            bus.ls_we    = v.we;
            bus.ls_addr  = v.addr;
            bus.ls_wdata = v.wdata;
            bus.ls_wmask = v.wmask;
        end
        sample();
        chk($sformatf("v%0d_if_gnt", idx), 64'(bus.if_gnt), 64'(v.is_if));
        chk($sformatf("v%0d_ls_gnt", idx), 64'(bus.ls_gnt), 64'(!v.is_if));
        next_cycle();
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        if (!mis) begin
            bus.m_gnt    = 1'b1;
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = v.mdata;
            sample();
            chk($sformatf("v%0d_m_req", idx), 64'(bus.m_req), 64'd1);
            chk($sformatf("v%0d_m_addr", idx), bus.m_addr, v.addr);
            chk($sformatf("v%0d_m_we", idx), 64'(bus.m_we), v.is_if ? 64'd0 : 64'(v.we));
            chk($sformatf("v%0d_m_wmask", idx), 64'(bus.m_wmask), v.is_if ? 64'd0 : 64'(v.wmask));
            if (!v.is_if) chk($sformatf("v%0d_m_wdata", idx), bus.m_wdata, v.wdata);
            next_cycle();
            bus.m_gnt    = 1'b0;
            bus.m_rvalid = 1'b0;
        end
        sample();
        chk($sformatf("v%0d_if_rvalid", idx), 64'(bus.if_rvalid), 64'(v.is_if));
        chk($sformatf("v%0d_ls_rvalid", idx), 64'(bus.ls_rvalid), 64'(!v.is_if));
        chk($sformatf("v%0d_err", idx), 64'(v.is_if ? bus.if_err : bus.ls_err), 64'(v.exp_err));
        if (v.is_if) chk($sformatf("v%0d_if_rdata", idx), 64'(bus.if_rdata), {32'd0, v.exp_rdata[31:0]});
        else         chk($sformatf("v%0d_ls_rdata", idx), bus.ls_rdata, v.exp_rdata);
        chk($sformatf("v%0d_m_req_resp", idx), 64'(bus.m_req), 64'd0);
        next_cycle();
        sample();
        chk($sformatf("v%0d_pulse", idx), 64'({bus.if_rvalid, bus.ls_rvalid}), 64'd0);
    endtask

    initial begin
        //        is_if addr                    we    wdata                  wmask  mdata                  err   exp_rdata
        vecs[0] = '{1'b0, 64'h0000_0000_8000_0010, 1'b0, 64'h0,                 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF};
        vecs[1] = '{1'b0, 64'h0000_0000_8000_0020, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
        vecs[2] = '{1'b1, 64'h0000_0000_8000_0004, 1'b0, 64'h0,                 8'h00, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0, 64'h0000_0000_AAAA_AAAA};
        vecs[3] = '{1'b1, 64'h0000_0000_8000_0000, 1'b0, 64'h0,                 8'h00, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0, 64'h0000_0000_BBBB_BBBB};
        vecs[4] = '{1'b1, 64'h0000_0000_8000_0002, 1'b0, 64'h0,                 8'h00, 64'h0,                 1'b1, 64'h0};
        vecs[5] = '{1'b1, 64'h0000_0000_8000_0001, 1'b0, 64'h0,                 8'h00, 64'h0,                 1'b1, 64'h0};
        vecs[6] = '{1'b1, 64'h0000_0000_8000_000C, 1'b0, 64'h0,                 8'h00, 64'h1234_5678_90AB_CDEF, 1'b0, 64'h0000_0000_1234_5678};

        bus.if_req = 1'b1;  bus.if_addr = 64'h8000_0000;
        bus.ls_req = 1'b1;  bus.ls_we = 1'b0; bus.ls_addr = 64'h8000_0040;
        bus.ls_wdata = '0;  bus.ls_wmask = '0;
        bus.m_gnt = 1'b0;   bus.m_rvalid = 1'b0; bus.m_rdata = '0;
        #2 sys_rst = 1'b1;
        sample();
        chk_all_zero("reset_outputs");
        sample();

        // Contention from reset: ls first, then strict alternation
        next_cycle();
        sys_rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            logic exp_ls;
            logic [63:0] md;
            exp_ls = (r % 2) == 0;
            md = 64'h1111_2222_3333_4444 + 64'(r);
            if (r > 0) next_cycle();
            sample();
            chk($sformatf("rr%0d_ls_gnt", r), 64'(bus.ls_gnt), 64'(exp_ls));
            chk($sformatf("rr%0d_if_gnt", r), 64'(bus.if_gnt), 64'(!exp_ls));
            next_cycle();
            bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = md;
            sample();
            chk($sformatf("rr%0d_no_gnt_req", r), 64'({bus.if_gnt, bus.ls_gnt}), 64'd0);
            next_cycle();
            bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0;
            sample();
            chk($sformatf("rr%0d_rvalid", r), 64'({bus.ls_rvalid, bus.if_rvalid}), exp_ls ? 64'd2 : 64'd1);
            chk($sformatf("rr%0d_rdata", r), exp_ls ? bus.ls_rdata : 64'(bus.if_rdata),
                exp_ls ? md : {32'd0, md[31:0]});
            chk($sformatf("rr%0d_no_gnt_resp", r), 64'({bus.if_gnt, bus.ls_gnt}), 64'd0);
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Load with m_gnt two cycles late and m_rvalid three cycles after that
        next_cycle();
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 64'h8000_0008; bus.ls_wmask = 8'h00;
        sample();
        chk("slow_gnt", 64'(bus.ls_gnt), 64'd1);
        next_cycle();
        bus.ls_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) bus.m_gnt = 1'b1;
            sample();
            chk($sformatf("slow_m_req_c%0d", c), 64'(bus.m_req), 64'd1);
            chk($sformatf("slow_m_addr_c%0d", c), bus.m_addr, 64'h8000_0008);
            next_cycle();
        end
        bus.m_gnt = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            if (c == 6) begin bus.m_rvalid = 1'b1; bus.m_rdata = 64'h1122_3344_5566_7788; end
            sample();
            chk($sformatf("slow_m_req_c%0d", c), 64'(bus.m_req), 64'd0);
            chk($sformatf("slow_quiet_c%0d", c), 64'(bus.ls_rvalid), 64'd0);
            next_cycle();
        end
        bus.m_rvalid = 1'b0;
        sample();
        chk("slow_rvalid", 64'(bus.ls_rvalid), 64'd1);
        chk("slow_rdata", bus.ls_rdata, 64'h1122_3344_5566_7788);
        chk("slow_err", 64'(bus.ls_err), 64'd0);
        next_cycle();
        sample();
        chk("slow_pulse", 64'(bus.ls_rvalid), 64'd0);

        // Timeout in WAIT: m_gnt given, m_rvalid withheld
        next_cycle();
        bus.ls_req = 1'b1; bus.ls_addr = 64'h8000_0100;
        sample();
        chk("to_gnt", 64'(bus.ls_gnt), 64'd1);
        next_cycle();
        bus.ls_req = 1'b0; bus.m_gnt = 1'b1;
        sample();
        chk("to_m_req", 64'(bus.m_req), 64'd1);
        next_cycle();
        bus.m_gnt = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            sample();
            chk($sformatf("to_quiet_c%0d", c), 64'(bus.ls_rvalid), 64'd0);
            next_cycle();
        end
        sample();
        chk("to_rvalid", 64'(bus.ls_rvalid), 64'd1);
        chk("to_err", 64'(bus.ls_err), 64'd1);
        chk("to_rdata", bus.ls_rdata, 64'd0);
        next_cycle();
        next_cycle();
        bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 64'h5555_5555_5555_5555;
        sample();
        chk("stray_idle", 64'({bus.if_rvalid, bus.ls_rvalid, bus.m_req}), 64'd0);
        next_cycle();
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0;
        sample();
        chk("stray_after", 64'({bus.if_rvalid, bus.ls_rvalid}), 64'd0);

        // Timeout in REQ: memory never accepts a fetch
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 64'h8000_0200;
        sample();
        chk("to2_gnt", 64'(bus.if_gnt), 64'd1);
        next_cycle();
        bus.if_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            sample();
            chk($sformatf("to2_m_req_c%0d", c), 64'({bus.m_req, bus.if_rvalid}), 64'd2);
            next_cycle();
        end
        sample();
        chk("to2_rvalid_err", 64'({bus.if_rvalid, bus.if_err}), 64'd3);
        chk("to2_rdata", 64'(bus.if_rdata), 64'd0);
        chk("to2_m_req_drop", 64'(bus.m_req), 64'd0);

        // Asynchronous reset in the middle of a WAIT
        next_cycle();
        bus.ls_req = 1'b1; bus.ls_addr = 64'h8000_0300;
        sample();
        chk("rst_gnt", 64'(bus.ls_gnt), 64'd1);
        next_cycle();
        bus.ls_req = 1'b0; bus.m_gnt = 1'b1;
        sample();
        next_cycle();
        bus.m_gnt = 1'b0;
        sample();
        chk("rst_pre_addr", bus.m_addr, 64'h8000_0300);
        #2 sys_rst = 1'b1;
        #1 chk_all_zero("rst_async_zero");
        next_cycle();
        bus.m_rvalid = 1'b1;
        sample();
        chk_all_zero("rst_held_zero");
        next_cycle();
        sys_rst = 1'b0;
        sample();
        chk("rst_stray", 64'({bus.if_rvalid, bus.ls_rvalid}), 64'd0);
        next_cycle();
        bus.m_rvalid = 1'b0;
        sample();
        chk("rst_stray2", 64'({bus.if_rvalid, bus.ls_rvalid}), 64'd0);
        run_vec(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
